bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
Sequential BCD-to-binary converter. It is the inverse of the team's binary-to-BCD display path: four packed BCD digits (keypad or preset entry) are turned back into an unsigned binary value for arithmetic and compare logic. It uses iterative reverse double-dabble: shift right one bit per cycle, then subtract 3 from each BCD nibble that is >= 8. A start/busy/done handshake frames each conversion.

Parameters:
DIGITS, 4, number of BCD digits in the input
BIN_W, 14, binary output width; must satisfy 10^DIGITS-1 < 2^BIN_W
CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > BIN_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  conversion request; sampled only in IDLE
bcd  input  4*DIGITS  packed digits: [15:12]=thousands, [11:8]=hundreds, [7:4]=tens, [3:0]=ones
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bin/err are updated
bin  output  BIN_W  converted value, registered, held until the next done
err  output  1  set at done if any input digit was > 9; held with bin

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, cnt=0, shift_reg=0, busy=0, done=0, bin=0, err=0. Reset mid-conversion aborts it. No done is issued for the aborted conversion.
- shift_reg width is 4*DIGITS+BIN_W. Upper field holds the BCD digits, lower field holds the binary result.
- IDLE: on a clock edge with start=1:
  - shift_reg <= {bcd, BIN_W'b0}, cnt <= 0, state <= SHIFT.
  - err_q <= OR over digits of (digit > 9).
- SHIFT: each edge computes t = shift_reg >> 1. For each digit field of t, if it is >= 8, subtract 3 from that field (4-bit arithmetic, no carry between digits). shift_reg <= corrected t, cnt <= cnt+1.
  - When cnt == BIN_W-1, state <= FINISH.
  - Exactly BIN_W shift cycles occur.
- FINISH (one cycle), then state <= IDLE:
  - bin <= err_q ? 0 : shift_reg[BIN_W-1:0]
  - err <= err_q, done <= 1
- done is high only in the cycle after FINISH, otherwise 0.
- busy = 1 in SHIFT and FINISH, 0 in IDLE, registered so it is glitch-free.
- Latency: start sampled at edge k -> bin/err/done valid after edge k+BIN_W+1 (15 cycles for the defaults).
- Back-to-back: start may be high during the done cycle (state is already IDLE). The next conversion begins, and throughput is one conversion per BIN_W+1 cycles.
- start while busy: ignored, not queued. bcd is captured only at the accepting edge, so later changes have no effect.
- Invalid digits: the conversion still runs the full BIN_W cycles, so latency is fixed. The result is forced to 0 and err=1.
- Between conversions bin and err hold their last values. done=0 in IDLE except for the pulse cycle.
- The BCD field is all-zero after the final shift when inputs are valid. The bench may assert this; it is not an output.

Decomposition:
- Shared package bcd_pkg:
  - state enum IDLE/SHIFT/FINISH (2-bit encoding)
  - DIGIT_MAX=9, ADJ_THRESH=8, ADJ_SUB=3
  - the default DIGITS/BIN_W pair, shared with the binary-to-BCD block
- Sub-module bcd_digit_adj: combinational 4-bit in -> 4-bit out, (d >= 8) ? d-3 : d. The block instantiates it DIGITS times via generate.

Test Plan:
- Zero and full scale:
  - bcd=16'h0000, start -> after 15 cycles done=1, bin=0, err=0.
  - bcd=16'h9999 -> bin=14'd9999 (0x270F), err=0.
- Latency and busy: bcd=16'h1023, start pulse at edge k -> busy=1 from k+1 through k+15, done exactly one cycle after edge k+15, bin=1023 (0x3FF).
- Invalid digit: bcd=16'h12A4 -> done after 15 cycles, err=1, bin=0. Then bcd=16'h0042 -> err=0, bin=42.
- Ignored start: start bcd=16'h0500, then pulse start with bcd=16'h0777 at cycle 5 -> single done, bin=500.
- Back-to-back: start held high with 16'h0001 then 16'h0002 applied in the done cycle -> bin=1 then bin=2, done pulses 15 cycles apart.
- Reset mid-operation: start 16'h4321, assert rst at cycle 7 for 2 cycles:
  - all outputs go to 0 immediately (asynchronously) and no done follows;
  - a new start with 16'h4321 -> bin=4321.
- Random: 1000 valid random digit sets -> bin equals the decimal value, err=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary conversion blocks.
//   - conversion FSM state encoding
//   - digit range / reverse double-dabble adjustment constants
//   - default DIGITS/BIN_W pair, also used by the binary-to-BCD display path
package bcd_pkg;

  localparam int unsigned DEF_DIGITS = 4;
  localparam int unsigned DEF_BIN_W  = 14;
  localparam int unsigned DEF_CNT_W  = 4;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB    = 4'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // A nibble above 9 is not a decimal digit.
  function automatic logic digit_invalid(input logic [3:0] d);
    return (d > DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD nibble.
// After a right shift, a nibble that is >= 8 received a bit worth 8 from
// the next-higher digit that should only be worth 5, so 3 is removed.
//   i_digit : nibble after the shift
//   o_digit : corrected nibble (no borrow into neighbouring digits)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit - ADJ_SUB) : i_digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// One right shift plus per-digit correction per cycle; BIN_W shift cycles
// followed by one FINISH cycle that publishes the result.
//   clk   : system clock, rising edge
//   rst   : asynchronous, active-high reset
//   start : conversion request, sampled only while idle
//   bcd   : packed digits, most significant digit in the top nibble
//   busy  : conversion in progress (registered)
//   done  : one-cycle pulse when bin/err update
//   bin   : converted value, held until the next done
//   err   : input contained a nibble > 9 (bin forced to 0), held with bin
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = DEF_DIGITS,
  parameter int unsigned BIN_W  = DEF_BIN_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SR_W-1:0]    r_shift;
  logic               r_err_q;
  logic               r_busy;
  logic               r_done;
  logic [BIN_W-1:0]   r_bin;
  logic               r_err;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SR_W-1:0]    w_shift_nxt;
  logic               w_err_q_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [BIN_W-1:0]   w_bin_nxt;
  logic               w_err_nxt;

  logic [SR_W-1:0]    w_t;
  logic [BCD_W-1:0]   w_adj;
  logic [SR_W-1:0]    w_shifted;
  logic               w_bcd_bad;

  // Shift the whole register right; the BCD field then gets corrected per digit.
  assign w_t = r_shift >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (w_t[BIN_W + 4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  assign w_shifted = {w_adj, w_t[BIN_W-1:0]};

  // Any non-decimal nibble in the request invalidates the whole conversion.
  always_comb begin
    w_bcd_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_bcd_bad = w_bcd_bad | digit_invalid(bcd[4*i +: 4]);
    end
  end

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_err_q_nxt = r_err_q;
    w_bin_nxt   = r_bin;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_shift_nxt = {bcd, {BIN_W{1'b0}}};
          w_cnt_nxt   = '0;
          w_err_q_nxt = w_bcd_bad;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift_nxt = w_shifted;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(BIN_W - 1)) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        w_bin_nxt   = r_err_q ? '0 : r_shift[BIN_W-1:0];
        w_err_nxt   = r_err_q;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // busy tracks the state being entered so it is a clean flop output.
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_err_q <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bin   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_err_q <= w_err_q_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_bin   <= w_bin_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bin  = r_bin;
  assign err  = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: the driver pushes the decimal value of
// each accepted request; a negedge monitor pops on every done pulse.
module tb_bcd_to_bin;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;
  localparam int          LAT    = BIN_W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4*DIGITS-1:0] bcd;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin;
  logic              err;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    int               acc;
    logic [15:0]      src;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int n_cmp = 0;
  int n_bad = 0;
  logic [BIN_W-1:0] last_bin = '0;
  logic             last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain decimal weighting of the digits.
  task automatic ref_conv(input logic [15:0] b, output logic [BIN_W-1:0] v, output logic e);
    int val;
    int d;
    val = 0;
    e   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d   = int'(b[4*i +: 4]);
      val = val * 10 + d;
      if (d > 9) e = 1'b1;
    end
    v = e ? '0 : BIN_W'(val);
  endtask

  task automatic push_exp(input logic [15:0] b, input int acc);
    exp_t x;
    ref_conv(b, x.bin, x.err);
    x.acc = acc;
    x.src = b;
    q.push_back(x);
  endtask

  // Monitor: result on each done pulse, hold of bin/err otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_bin = '0;
      last_err = 1'b0;
    end else if (done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got bin=%0d err=%0b expected no done", bin, err);
      end else begin
        e_mon = q.pop_front();
        check("bin", 32'(bin), 32'(e_mon.bin));
        check("err", 32'(err), 32'(e_mon.err));
        check("latency", 32'(cyc - e_mon.acc), 32'(LAT));
        check("busy_at_done", 32'(busy), 32'd0);
      end
      last_bin = bin;
      last_err = err;
    end else begin
      check("hold_bin", 32'(bin), 32'(last_bin));
      check("hold_err", 32'(err), 32'(last_err));
    end
  end

  // Issue one request once idle; entered and left at a negedge.
  task automatic start_conv(input logic [15:0] b);
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle_timeout", 32'(busy), 32'd0);
    bcd   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_exp(b, cyc);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    int t;
    int acc;

    rst   = 1'b1;
    start = 1'b0;
    bcd   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin",  32'(bin),  32'd0);
    check("rst_err",  32'(err),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero and full scale.
    start_conv(16'h0000);
    wait_drain();
    start_conv(16'h9999);
    wait_drain();

    // Latency and busy profile.
    bcd   = 16'h1023;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc   = cyc;
    push_exp(16'h1023, acc);
    check("busy_rise", 32'(busy), 32'd1);
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      check("busy_mid", 32'(busy), 32'd1);
      check("no_early_done", 32'(done), 32'd0);
    end
    wait_drain();

    // Invalid digit, then recovery.
    start_conv(16'h12A4);
    wait_drain();
    start_conv(16'h0042);
    wait_drain();

    // Start while busy is ignored and bcd changes do not leak in.
    start_conv(16'h0500);
    repeat (4) @(negedge clk);
    bcd   = 16'h0777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);

    // Back-to-back: start held high, second request accepted in the done cycle.
    bcd   = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    push_exp(16'h0001, cyc);
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("b2b_done_seen", 32'(done), 32'd1);
    bcd = 16'h0002;
    @(negedge clk);
    start = 1'b0;
    push_exp(16'h0002, cyc);
    check("b2b_accept", 32'(busy), 32'd1);
    wait_drain();

    // Reset mid-conversion: async clear, no done for the aborted request.
    start_conv(16'h4321);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_bin",  32'(bin),  32'd0);
    check("arst_err",  32'(err),  32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    repeat (20) @(negedge clk);
    start_conv(16'h4321);
    wait_drain();

    // Random valid digit sets.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(9));
      start_conv(r);
    end
    wait_drain();

    // A few random sets that may contain non-decimal nibbles.
    for (int n = 0; n < 40; n++) begin
      r = 16'($urandom);
      start_conv(r);
    end
    wait_drain();

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
